// File: rtl/haar_rom_pkg.sv
// Shared defaults and FSM encoding for the Haar feature ROM reader.
package haar_rom_pkg;

  localparam int HAAR_ADDR_WIDTH   = 12;
  localparam int HAAR_DATA_WIDTH   = 8;
  localparam int HAAR_RECORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_OUT    = 2'd2,
    ST_FINISH = 2'd3
  } haar_state_t;

  function automatic logic state_is_busy(input haar_state_t st);
    return (st == ST_READ) || (st == ST_OUT);
  endfunction

endpackage

// File: rtl/haar_rom_reader_if.sv
// Record stream from the ROM reader to the classifier (valid/ready).
interface haar_rom_reader_if
  import haar_rom_pkg::*;
#(
  parameter int DATA_WIDTH   = HAAR_DATA_WIDTH,
  parameter int RECORD_BYTES = HAAR_RECORD_BYTES
) ();

  logic [RECORD_BYTES*DATA_WIDTH-1:0] rec_data;
  logic                               rec_valid;
  logic                               rec_ready;
  logic                               rec_last;

  modport master (
    output rec_data,
    output rec_valid,
    output rec_last,
    input  rec_ready
  );

  modport slave (
    input  rec_data,
    input  rec_valid,
    input  rec_last,
    output rec_ready
  );

endinterface

// File: rtl/haar_byte_packer.sv
// Byte-lane record assembler: new bytes enter the top lane and shift down,
// so after RECORD_BYTES captures the first byte sits in the lowest lane.
module haar_byte_packer
  import haar_rom_pkg::*;
#(
  parameter int DATA_WIDTH   = HAAR_DATA_WIDTH,
  parameter int RECORD_BYTES = HAAR_RECORD_BYTES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               load,
  input  logic                               shift,
  input  logic [DATA_WIDTH-1:0]              din,
  output logic [RECORD_BYTES*DATA_WIDTH-1:0] dout
);

  localparam int REC_W = RECORD_BYTES * DATA_WIDTH;

  logic [REC_W-1:0] lanes_q;

  // load starts a fresh record (stale lanes zeroed); shift appends the next byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes_q <= '0;
    end else if (clear) begin
      lanes_q <= '0;
    end else if (load) begin
      lanes_q <= {din, {(REC_W-DATA_WIDTH){1'b0}}};
    end else if (shift) begin
      lanes_q <= {din, lanes_q[REC_W-1:DATA_WIDTH]};
    end
  end

  assign dout = lanes_q;

endmodule

// File: rtl/haar_rom_reader.sv
// Sequencer in front of the single-port feature ROM: fetches runs of packed records.
// Optional build macro HAAR_ROM_READER_CHECKSUM_EN adds an XOR checksum output.
module haar_rom_reader
  import haar_rom_pkg::*;
#(
  parameter int ADDR_WIDTH   = HAAR_ADDR_WIDTH,
  parameter int DATA_WIDTH   = HAAR_DATA_WIDTH,
  parameter int RECORD_BYTES = HAAR_RECORD_BYTES,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_records,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_q,
  haar_rom_reader_if.master     rec,
  output logic                  busy,
  output logic                  done
`ifdef HAAR_ROM_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam int BCW = $clog2(RECORD_BYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(RECORD_BYTES);
  localparam logic [BCW-1:0] FIRST_CAP = BCW'(1);

  haar_state_t          state_q, state_d;
  logic [BCW-1:0]       byte_cnt;
  logic [CNT_WIDTH-1:0] rec_left;
  logic                 rec_valid_q;
  logic                 rec_last_q;
  logic                 start_acc;
  logic                 handshake;
  logic                 capture;
  logic                 first_cap;
  logic [RECORD_BYTES*DATA_WIDTH-1:0] packed_rec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // byte_cnt k in READ: rom_address shows byte k, rom_q returns byte k-1
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    handshake = 1'b0;
    capture   = 1'b0;
    first_cap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (num_records != '0) ? ST_READ : ST_FINISH;
        end
      end
      ST_READ: begin
        capture   = (byte_cnt != '0);
        first_cap = (byte_cnt == FIRST_CAP);
        if (byte_cnt == LAST_BYTE) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (rec_valid_q && rec.rec_ready) begin
          handshake = 1'b1;
          state_d   = (rec_left == CNT_WIDTH'(1)) ? ST_FINISH : ST_READ;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The address advances past the record's last byte, so a following READ
  // resumes at the next address with no gap and OUT holds it frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_address <= '0;
      byte_cnt    <= '0;
      rec_left    <= '0;
      rec_valid_q <= 1'b0;
      rec_last_q  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= state_is_busy(state_d);
      done <= (state_d == ST_FINISH);
      if (start_acc) begin
        rom_address <= base_addr;
        rec_left    <= num_records;
      end
      if (state_q == ST_READ) begin
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt    <= '0;
          rec_valid_q <= 1'b1;
          rec_last_q  <= (rec_left == CNT_WIDTH'(1));
        end else begin
          byte_cnt    <= byte_cnt + BCW'(1);
          rom_address <= rom_address + ADDR_WIDTH'(1);
        end
      end
      if (handshake) begin
        rec_valid_q <= 1'b0;
        rec_last_q  <= 1'b0;
        rec_left    <= rec_left - CNT_WIDTH'(1);
      end
    end
  end

  haar_byte_packer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RECORD_BYTES (RECORD_BYTES)
  ) u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (start_acc),
    .load  (capture && first_cap),
    .shift (capture && !first_cap),
    .din   (rom_q),
    .dout  (packed_rec)
  );

  assign rec.rec_data  = packed_rec;
  assign rec.rec_valid = rec_valid_q;
  assign rec.rec_last  = rec_last_q;

`ifdef HAAR_ROM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (capture) begin
      checksum_q <= checksum_q ^ rom_q;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_haar_rom_reader.sv
// Scoreboard bench for haar_rom_reader with a behavioural ROM holding byte[a] = a[7:0].
module tb_haar_rom_reader;
  import haar_rom_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RB = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_records;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_q = '0;
  logic          busy;
  logic          done;
`ifdef HAAR_ROM_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  haar_rom_reader_if #(.DATA_WIDTH(DW), .RECORD_BYTES(RB)) rec_if ();

  haar_rom_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RECORD_BYTES(RB), .CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_records (num_records),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rec         (rec_if.master),
    .busy        (busy),
    .done        (done)
`ifdef HAAR_ROM_READER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  // ROM: address registered in the DUT, data registered here -> one cycle latency
  always @(posedge clk) rom_q <= rom_address[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          vcyc;
  } rec_t;

  rec_t exp_q[$];
  int   done_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard on each handshake and on each done pulse
  logic          vseen = 1'b0;
  int            vcyc  = 0;
  logic [31:0]   hold_d;
  logic [AW-1:0] hold_a;
  rec_t          e;

  always @(negedge clk) begin
    if (!reset) begin
      vseen = 1'b0;
    end else begin
      if (rec_if.rec_valid) begin
        if (!vseen) begin
          vseen  = 1'b1;
          vcyc   = cyc;
          hold_d = rec_if.rec_data;
          hold_a = rom_address;
        end else begin
          chk("hold_data", rec_if.rec_data, hold_d);
          chk("hold_addr", rom_address, hold_a);
        end
        if (rec_if.rec_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_record: got %0h, expected none", rec_if.rec_data);
          end else begin
            e = exp_q.pop_front();
            chk("rec_data", rec_if.rec_data, e.data);
            chk("rec_last", rec_if.rec_last, e.last);
            chk("valid_cycle", vcyc, e.vcyc);
          end
          vseen = 1'b0;
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
          chk("busy_at_done", busy, 1'b0);
        end
      end
    end
  end

  task automatic push_rec(input logic [31:0] d, input logic l, input int c);
    rec_t r;
    r.data = d; r.last = l; r.vcyc = c;
    exp_q.push_back(r);
  endtask

  task automatic run(input logic [AW-1:0] base, input logic [CW-1:0] num, output int t);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_records = num; t = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 12'hABC; num_records = 8'hEE;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      total++;
      $display("FAIL %s: done got 0 after 60 cycles, expected 1", name);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  int t;

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; num_records = '0;
    rec_if.rec_ready = 1'b1;
    #12;
    chk("rst_addr",  rom_address, 0);
    chk("rst_data",  rec_if.rec_data, 0);
    chk("rst_valid", rec_if.rec_valid, 0);
    chk("rst_last",  rec_if.rec_last, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    @(posedge clk); #1; reset = 1'b1;

    // 1: two records back to back
    run(12'h010, 8'd2, t);
    chk("s1_busy", busy, 1);
    push_rec(32'h13121110, 1'b0, t + 6);
    push_rec(32'h17161514, 1'b1, t + 12);
    done_q.push_back(t + 13);
    wait_done("s1_done");

    // 2: consumer stalls 5 cycles on the first record
    rec_if.rec_ready = 1'b0;
    run(12'h010, 8'd2, t);
    push_rec(32'h13121110, 1'b0, t + 6);
    push_rec(32'h17161514, 1'b1, t + 17);
    done_q.push_back(t + 18);
    while (cyc != t + 11) begin @(posedge clk); #1; end
    chk("s2_frozen_addr", rom_address, 12'h014);
    chk("s2_stall_data", rec_if.rec_data, 32'h13121110);
    rec_if.rec_ready = 1'b1;
    wait_done("s2_done");

    // 3: address wrap at the top of the ROM
    run(12'hFFE, 8'd1, t);
    push_rec(32'h0100FFFE, 1'b1, t + 6);
    done_q.push_back(t + 7);
    wait_done("s3_done");

    // 4: empty run, with a second start ignored in the FINISH cycle
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'h100; num_records = 8'd0; t = cyc;
    done_q.push_back(t + 1);
    @(posedge clk); #1;
    chk("s4_busy_t1", busy, 0);
    start = 1'b1; base_addr = 12'h200; num_records = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s4_busy", busy, 0);
      chk("s4_valid", rec_if.rec_valid, 0);
      @(posedge clk); #1;
    end

    // 5: reset in the middle of a READ, then a clean run
    run(12'h030, 8'd2, t);
    while (cyc != t + 3) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("s5_addr",  rom_address, 0);
    chk("s5_data",  rec_if.rec_data, 0);
    chk("s5_valid", rec_if.rec_valid, 0);
    chk("s5_last",  rec_if.rec_last, 0);
    chk("s5_busy",  busy, 0);
    chk("s5_done",  done, 0);
    @(posedge clk); #1; reset = 1'b1;
    run(12'h020, 8'd1, t);
    push_rec(32'h23222120, 1'b1, t + 6);
    done_q.push_back(t + 7);
    wait_done("s5_done_run");

`ifdef HAAR_ROM_READER_CHECKSUM_EN
    // 6: XOR checksum over 0x11..0x14
    run(12'h011, 8'd1, t);
    push_rec(32'h14131211, 1'b1, t + 6);
    done_q.push_back(t + 7);
    wait_done("s6_done");
    chk("s6_checksum", checksum, 8'h04);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/haar_rom_reader.md
Name: haar_rom_reader

Overview:
- Sequencer directly upstream of the single-port `rom` (registered address, registered `q`, loaded from a `.mif`).
- Generates ROM addresses and captures the returned bytes.
- Packs RECORD_BYTES consecutive bytes into one Haar feature record.
- Streams records to the classifier through a valid/ready handshake; one command fetches a run of records from a base address.

Parameters:
- ADDR_WIDTH, 12, ROM address width; must match the `rom` instance.
- DATA_WIDTH, 8, ROM word width.
- RECORD_BYTES, 4, ROM words per record; minimum 2.
- CNT_WIDTH, 8, width of the record count.

Ports:
- clk  in  1  rising-edge clock, shared with `rom`.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first ROM address of the run.
- num_records  in  CNT_WIDTH  records to fetch; 0 is legal.
- rom_address  out  ADDR_WIDTH  registered address to `rom.address`.
- rom_q  in  DATA_WIDTH  from `rom.q`.
- rec_data  out  RECORD_BYTES*DATA_WIDTH  packed record; first byte read is the least-significant byte.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts.
- rec_last  out  1  qualifies the final record of the run.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at run end.

Behaviour:
- Reset (async assert, low): state=IDLE; rom_address, rec_data, rec_valid, rec_last, busy, done, and internal counters all 0.
- ROM timing contract: an address on rom_address during cycle N produces its data on rom_q during cycle N+1.
- FSM states: IDLE, READ, OUT, FINISH.
- IDLE:
  - start=1 with num_records>0 -> READ; rom_address<=base_addr; busy<=1; count latched.
  - start=1 with num_records=0 -> FINISH directly; no address is issued.
- READ:
  - rom_address increments once per cycle for RECORD_BYTES cycles.
  - Each rom_q byte is shifted into its byte lane one cycle later.
  - After the last byte is captured -> OUT, with rec_valid=1.
  - rec_last=1 if this is the final record.
- OUT:
  - rec_data, rec_valid and rec_last are held stable while rec_ready=0.
  - rom_address is frozen; no reads are issued.
  - On the handshake (rec_valid & rec_ready): rec_valid<=0.
  - If records remain -> READ, continuing from the next address (no gaps in the address sequence); otherwise -> FINISH.
- FINISH: done=1 for exactly one cycle; busy=0 in that cycle; -> IDLE.
- Latency: start (or handshake) sampled in cycle t -> addresses in t+1..t+RECORD_BYTES -> rec_valid high in t+RECORD_BYTES+2.
- Throughput with rec_ready=1: one record per RECORD_BYTES+2 cycles.
- Address arithmetic is modulo 2^ADDR_WIDTH; FFF wraps to 000 silently.
- start while busy is ignored; base_addr and num_records are sampled only on an accepted start.
- rec_ready while rec_valid=0 has no effect.
- Reset asserted mid-run aborts immediately to the reset state; no done pulse is produced.

Optional Feature:
- Macro: HAAR_ROM_READER_CHECKSUM_EN.
- Defined:
  - Adds output `checksum` [DATA_WIDTH-1:0].
  - Cleared to 0 on an accepted start.
  - XOR-accumulates every captured rom_q byte.
  - Final value is valid from the done cycle until the next start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package haar_rom_pkg:
  - default ADDR_WIDTH, DATA_WIDTH and RECORD_BYTES constants;
  - FSM state encoding (IDLE, READ, OUT, FINISH).
- Sub-module haar_byte_packer:
  - RECORD_BYTES-lane shift/capture register with load, shift and clear controls;
  - instantiated once.
- Address/count sequencing and the FSM stay in the top level.
- Bench instantiates `rom` alongside the DUT, with memory.mif holding byte[a] = a[7:0].

Test Plan:
1. base=0x010, num=2, rec_ready=1, start at cycle t:
   - rec_data=0x13121110 valid at t+6;
   - rec_data=0x17161514 with rec_last=1 valid at t+12;
   - done at t+13.
2. As scenario 1, with rec_ready held low 5 cycles after the first rec_valid:
   - rec_data is stable at 0x13121110;
   - rom_address is frozen;
   - the second record appears 6 cycles after the handshake.
3. base=0xFFE, num=1: addresses FFE, FFF, 000, 001 -> rec_data=0x0100FFFE, rec_last=1.
4. num=0: done=1 at t+1; rec_valid never asserts; busy never asserts; a second start pulse during the run is ignored.
5. reset pulled low at t+3 of a READ:
   - all outputs are 0 within the same cycle;
   - a later start with base=0x020, num=1 yields 0x23222120.
6. HAAR_ROM_READER_CHECKSUM_EN defined, base=0x011, num=1: checksum=0x04 at done.
